// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a simple command/response handshake
module axi_lite_cmd_master #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        axi_aclk,
    input  logic        axi_areset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_resp,

    output logic        m_axi_awvalid,
    output logic [31:0] m_axi_awaddr,
    input  logic        m_axi_awready,
    output logic [2:0]  m_axi_awprot,

    output logic        m_axi_wvalid,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    input  logic        m_axi_wready,

    input  logic        m_axi_bvalid,
    input  logic [1:0]  m_axi_bresp,
    output logic        m_axi_bready,

    output logic        m_axi_arvalid,
    output logic [31:0] m_axi_araddr,
    input  logic        m_axi_arready,
    output logic [2:0]  m_axi_arprot,

    input  logic        m_axi_rvalid,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    output logic        m_axi_rready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    logic [2:0] state;

    // A channel counts as finished once its valid is low or is handshaking this cycle.
    logic aw_finishing;
    logic w_finishing;

    assign aw_finishing = !m_axi_awvalid || m_axi_awready;
    assign w_finishing  = !m_axi_wvalid  || m_axi_wready;

    assign m_axi_awprot = PROT;
    assign m_axi_arprot = PROT;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 32'd0;
            rsp_resp      <= 2'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= 32'd0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= 32'd0;
            m_axi_wstrb   <= 4'd0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= 32'd0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_ADDR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                WR_ADDR: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_finishing && w_finishing) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        rsp_resp     <= m_axi_bresp;
                        rsp_data     <= 32'd0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RD_ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready <= 1'b0;
                        rsp_data     <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end

                RSP: begin
                    // cmd_ready rises together with the return to IDLE so it is high the next cycle.
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - vector table plus randomized transactions against a memory-backed slave and reference model
module tb_axi_lite_cmd_master;

    localparam int BUDGET = 100;

    logic        clk = 1'b0;
    logic        axi_areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic [3:0]  cmd_wstrb = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        m_axi_awvalid;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awready = 1'b0;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_wvalid;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wready = 1'b0;
    logic        m_axi_bvalid = 1'b0;
    logic [1:0]  m_axi_bresp = 2'd0;
    logic        m_axi_bready;
    logic        m_axi_arvalid;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arready = 1'b0;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_rvalid = 1'b0;
    logic [31:0] m_axi_rdata = 32'd0;
    logic [1:0]  m_axi_rresp = 2'd0;
    logic        m_axi_rready;

    axi_lite_cmd_master #(.PROT(3'b000)) dut (
        .axi_aclk      (clk),
        .axi_areset    (axi_areset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_resp      (rsp_resp),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awready (m_axi_awready),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arready (m_axi_arready),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        int          ar_dly;
        int          r_dly;
        int          rsp_dly;
        logic [1:0]  resp;
        bit          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];

    logic any_out;
    assign any_out = |{cmd_ready, rsp_valid, rsp_data, rsp_resp, m_axi_awvalid, m_axi_awaddr,
                       m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready, m_axi_arvalid,
                       m_axi_araddr, m_axi_rready};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input int awd, input int wd, input int bd,
                                input int ard, input int rd, input int rspd, input logic [1:0] resp,
                                input bit hold, input logic [31:0] ed, input logic [1:0] er,
                                input int el);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = d; v.strb = s;
        v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
        v.rsp_dly = rspd; v.resp = resp; v.hold = hold;
        v.exp_data = ed; v.exp_resp = er; v.exp_lat = el;
        return v;
    endfunction

    task automatic idle_slave();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0; rsp_ready = 1'b0;
    endtask

    // One command end to end; the slave answers after the per-channel delays in v.
    task automatic run_txn(input vec_t v, input string tag);
        int k, aw_n, w_n, ar_n, b_n, r_n, rsp_n, viol, lat;
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, seen, done;
        logic [31:0] got_data, cap_addr, cap_wdata;
        logic [3:0]  cap_strb;
        logic [1:0]  got_resp;
        aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0; rsp_n = 0; viol = 0; lat = 0;
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; seen = 0; done = 0;
        got_data = 32'd0; got_resp = 2'd0; cap_addr = 32'd0; cap_wdata = 32'd0; cap_strb = 4'd0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.strb;
        k = 0;
        while (!cmd_ready && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check({tag, "/accept_timeout"}, 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end

        k = 0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (v.hold) begin
                cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom;
                cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            if (cmd_ready) viol++;
            if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) viol++;

            if (m_axi_bready && !(aw_hs && w_hs)) viol++;
            m_axi_bvalid = 1'b0;
            m_axi_bresp  = 2'($urandom);
            if (aw_hs && w_hs && !b_hs) begin
                if (b_n >= v.b_dly) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = v.resp;
                    if (m_axi_bready) begin
                        b_hs = 1;
                        slv_mem[cap_addr[5:2]] = merge(slv_mem[cap_addr[5:2]], cap_wdata, cap_strb);
                    end
                end else begin
                    b_n++;
                end
            end

            if (m_axi_rready && !ar_hs) viol++;
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = $urandom;
            m_axi_rresp  = 2'($urandom);
            if (ar_hs && !r_hs) begin
                if (r_n >= v.r_dly) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = slv_mem[cap_addr[5:2]];
                    m_axi_rresp  = v.resp;
                    if (m_axi_rready) r_hs = 1;
                end else begin
                    r_n++;
                end
            end

            if (m_axi_awvalid) begin
                if (aw_hs || !v.write || m_axi_awaddr !== v.addr) viol++;
                aw_n++;
                m_axi_awready = (aw_n > v.aw_dly);
                if (m_axi_awready) begin aw_hs = 1; cap_addr = m_axi_awaddr; end
            end else begin
                m_axi_awready = 1'b0;
                if (aw_n > 0 && !aw_hs) viol++;
            end

            if (m_axi_wvalid) begin
                if (w_hs || !v.write || m_axi_wdata !== v.wdata || m_axi_wstrb !== v.strb) viol++;
                w_n++;
                m_axi_wready = (w_n > v.w_dly);
                if (m_axi_wready) begin w_hs = 1; cap_wdata = m_axi_wdata; cap_strb = m_axi_wstrb; end
            end else begin
                m_axi_wready = 1'b0;
                if (w_n > 0 && !w_hs) viol++;
            end

            if (m_axi_arvalid) begin
                if (ar_hs || v.write || m_axi_araddr !== v.addr) viol++;
                ar_n++;
                m_axi_arready = (ar_n > v.ar_dly);
                if (m_axi_arready) begin ar_hs = 1; cap_addr = m_axi_araddr; end
            end else begin
                m_axi_arready = 1'b0;
                if (ar_n > 0 && !ar_hs) viol++;
            end

            rsp_ready = 1'b0;
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1; got_data = rsp_data; got_resp = rsp_resp; lat = k;
                    if (!(b_hs || r_hs)) viol++;
                end else if (rsp_data !== got_data || rsp_resp !== got_resp) begin
                    viol++;
                end
                if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid || m_axi_bready || m_axi_rready) viol++;
                rsp_n++;
                if (rsp_n > v.rsp_dly) begin
                    rsp_ready = 1'b1;
                    done = 1;
                    cmd_valid = 1'b0;
                end
            end
        end

        if (!done) begin
            check({tag, "/rsp_timeout"}, 32'(rsp_valid), 32'd1);
        end else begin
            @(negedge clk);
            rsp_ready = 1'b0;
            check({tag, "/post_rsp_valid_cmd_ready"}, 32'({rsp_valid, cmd_ready}), 32'b01);
        end
        idle_slave();

        check({tag, "/rsp_data"}, got_data, v.exp_data);
        check({tag, "/rsp_resp"}, 32'(got_resp), 32'(v.exp_resp));
        check({tag, "/protocol_violations"}, 32'(viol), 32'd0);
        if (v.write) begin
            check({tag, "/awvalid_cycles"}, 32'(aw_n), 32'(v.aw_dly + 1));
            check({tag, "/wvalid_cycles"}, 32'(w_n), 32'(v.w_dly + 1));
        end else begin
            check({tag, "/arvalid_cycles"}, 32'(ar_n), 32'(v.ar_dly + 1));
        end
        if (v.exp_lat > 0) check({tag, "/latency"}, 32'(lat), 32'(v.exp_lat));
    endtask

    // Reference memory: byte-strobed writes, applied at command level.
    task automatic ref_apply(input vec_t v);
        if (v.write) ref_mem[v.addr[5:2]] = merge(ref_mem[v.addr[5:2]], v.wdata, v.strb);
    endtask

    initial begin
        vec_t tbl [10];
        vec_t v;
        int k;
        logic [31:0] tmp;
        logic [3:0] idx;

        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end

        //         w     addr          wdata          strb  aw w  b  ar r  rsp resp  hold exp_data       er    lat
        tbl[0] = mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0000_0000, 2'b00, 3);
        tbl[1] = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'hDEAD_BEEF, 2'b00, 3);
        tbl[2] = mk(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0000_0000, 2'b00, 3);
        tbl[3] = mk(1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 0, 3, 0, 0, 2'b00, 0, 32'h1234_5678, 2'b00, 6);
        tbl[4] = mk(1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 2, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0000_0000, 2'b10, 5);
        tbl[5] = mk(1'b1, 32'h0000_0010, 32'h0000_5555, 4'h3, 0, 3, 1, 0, 0, 0, 2'b01, 0, 32'h0000_0000, 2'b01, 0);
        tbl[6] = mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 0, 0, 5, 2'b11, 1, 32'hDEAD_5555, 2'b11, 0);
        tbl[7] = mk(1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 0, 2, 0, 2'b00, 0, 32'hA5A5_A5A5, 2'b00, 0);
        tbl[8] = mk(1'b1, 32'h0000_0008, 32'h1122_3344, 4'hA, 1, 1, 2, 0, 0, 5, 2'b00, 1, 32'h0000_0000, 2'b00, 0);
        tbl[9] = mk(1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 0, 1, 1, 1, 2'b10, 0, 32'h11A5_33A5, 2'b10, 0);

        repeat (3) @(negedge clk);
        check("reset/outputs_zero", 32'(any_out), 32'd0);
        axi_areset = 1'b0;
        @(negedge clk);
        check("reset/cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("tbl%0d", i));
            ref_apply(tbl[i]);
        end

        // Reset while waiting for the write response.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020;
        cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
        k = 0;
        while (!cmd_ready && k < BUDGET) begin @(negedge clk); k++; end
        @(negedge clk);
        cmd_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        k = 0;
        while (!m_axi_bready && k < BUDGET) begin @(negedge clk); k++; end
        check("midrst/in_wr_resp", 32'(m_axi_bready), 32'd1);
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        #2 axi_areset = 1'b1;
        #1 check("midrst/outputs_zero_async", 32'(any_out), 32'd0);
        @(negedge clk);
        check("midrst/outputs_zero_held", 32'(any_out), 32'd0);
        axi_areset = 1'b0;
        @(negedge clk);
        check("midrst/cmd_ready_after_release", 32'(cmd_ready), 32'd1);
        run_txn(mk(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 1, 0, 2'b00, 0,
                   ref_mem[8], 2'b00, 0), "midrst/read");

        for (int i = 0; i < 40; i++) begin
            tmp = $urandom;
            idx = 4'($urandom_range(0, 15));
            v.write   = 1'($urandom);
            v.addr    = {tmp[31:6], idx, 2'b00};
            v.wdata   = $urandom;
            v.strb    = 4'($urandom);
            v.aw_dly  = $urandom_range(0, 3);
            v.w_dly   = $urandom_range(0, 3);
            v.b_dly   = $urandom_range(0, 3);
            v.ar_dly  = $urandom_range(0, 3);
            v.r_dly   = $urandom_range(0, 3);
            v.rsp_dly = $urandom_range(0, 4);
            v.resp    = 2'($urandom);
            v.hold    = 1'($urandom);
            v.exp_data = v.write ? 32'd0 : ref_mem[idx];
            v.exp_resp = v.resp;
            v.exp_lat  = (v.write ? (v.aw_dly + v.w_dly + v.b_dly) : (v.ar_dly + v.r_dly)) == 0 ? 3 : 0;
            run_txn(v, $sformatf("rnd%0d", i));
            ref_apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master
Interface
REQ-001 SHALL have parameter: PROT, 3'b000, value driven on m_axi_awprot and m_axi_arprot.
REQ-002 SHALL have port: axi_aclk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: axi_areset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command request.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port: cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port: cmd_addr  input  32  target byte address.
REQ-008 SHALL have port: cmd_wdata  input  32  write data.
REQ-009 SHALL have port: cmd_wstrb  input  4  write byte strobes.
REQ-010 SHALL have port: rsp_valid  output  1  response available.
REQ-011 SHALL have port: rsp_ready  input  1  response consumed.
REQ-012 SHALL have port: rsp_data  output  32  read data, 0 for writes.
REQ-013 SHALL have port: rsp_resp  output  2  AXI response code.
REQ-014 SHALL have ports m_axi_awvalid out 1, m_axi_awaddr out 32, m_axi_awready in 1, m_axi_awprot out 3: write address channel.
REQ-015 SHALL have ports m_axi_wvalid out 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wready in 1: write data channel.
REQ-016 SHALL have ports m_axi_bvalid in 1, m_axi_bresp in 2, m_axi_bready out 1: write response channel.
REQ-017 SHALL have ports m_axi_arvalid out 1, m_axi_araddr out 32, m_axi_arready in 1, m_axi_arprot out 3: read address channel.
REQ-018 SHALL have ports m_axi_rvalid in 1, m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rready out 1: read data channel.
Function
REQ-019 SHALL implement FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction outstanding at a time.
REQ-020 SHALL assert cmd_ready (registered) only in IDLE; on cmd_valid&&cmd_ready latch addr/wdata/wstrb, go to WR_ADDR (write) or RD_ADDR (read).
REQ-021 SHALL, in WR_ADDR, assert awvalid and wvalid from the cycle after acceptance; each drops the cycle after its own handshake, independently; AW before W, W before AW, or both same cycle all legal.
REQ-022 SHALL go to WR_RESP once both AW and W handshakes are done; bready=1 only in WR_RESP; on bvalid&&bready capture bresp into rsp_resp, rsp_data=0, go to RSP.
REQ-023 SHALL, in RD_ADDR, hold arvalid until arready; then RD_DATA with rready=1; on rvalid&&rready capture rdata/rresp, go to RSP.
REQ-024 SHALL hold awvalid/wvalid/arvalid and their address/data/strobe stable until handshake; no valid withdrawn before handshake.
REQ-025 SHALL, in RSP, assert rsp_valid with rsp_data/rsp_resp stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE, cmd_ready high the following cycle.
REQ-026 SHALL achieve, with all slave readies/valids high immediately, accept at cycle N, aw/ar valid at N+1, b/r handshake at N+2, rsp_valid at N+3.
REQ-027 SHALL pass bresp/rresp unmodified (OKAY, EXOKAY, SLVERR, DECERR); no timeout or abort; stall indefinitely on a silent slave.
REQ-028 SHALL ignore cmd_valid outside IDLE and never issue a second request before rsp handshake.
Reset
REQ-029 SHALL on axi_areset immediately force IDLE and drive all outputs 0 (cmd_ready, rsp_valid, rsp_data, rsp_resp, all m_axi valid/ready/addr/data/strb), including mid-transaction; cmd_ready rises on first axi_aclk edge after release.
Verification
REQ-030 Write addr=0x0000_0010 data=0xDEADBEEF strb=0xF, slave always ready, bresp=00 -> awaddr=0x10, wdata=0xDEADBEEF at N+1, rsp_valid at N+3, rsp_resp=00, rsp_data=0.
REQ-031 Read addr=0x0000_0004, arready delayed 3 cycles, rdata=0x12345678 rresp=00 -> arvalid held 4 cycles stable, rsp_data=0x12345678, rsp_resp=00.
REQ-032 Write with wready 2 cycles before awready, then bresp=10 -> wvalid drops after W handshake, awvalid held until AW handshake, rsp_resp=10.
REQ-033 rsp_ready held low 5 cycles with new cmd_valid pending -> rsp_valid/data stable, cmd_ready=0, no AXI valid until rsp handshake.
REQ-034 axi_areset asserted during WR_RESP -> all outputs 0 at once, cmd_ready=1 one cycle after release, next read completes normally.
